// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command path: op encoding, response
// status codes and the command sequencer state encoding.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_DIV  = 3'b100,
    OP_SQRT = 3'b101,
    OP_GCD  = 3'b110,
    OP_RSVD = 3'b111
  } calc_op_e;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BAD_OP  = 8'h01;
  localparam logic [7:0] STAT_TIMEOUT = 8'h02;

  typedef enum logic [2:0] {
    ST_RX_OP,
    ST_RX_A,
    ST_RX_B,
    ST_ISSUE,
    ST_WAIT,
    ST_TX_STATUS,
    ST_TX_RES
  } seq_state_e;

  // Upper five bits must be clear and the low three must name a real operation.
  function automatic logic op_code_valid(input logic [7:0] code);
    return (code[7:3] == 5'd0) &&
           (code[2:0] >= 3'(OP_ADD)) && (code[2:0] <= 3'(OP_GCD));
  endfunction

endpackage

// File: rtl/calc_tx_serializer.sv
// Response byte serializer: loads a status byte plus an NB-byte result and
// shifts len bytes out, LSB first, under a valid/ready handshake.
module calc_tx_serializer #(
  parameter int NB = 2,
  parameter int LW = $clog2(NB + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [7:0]      status,
  input  logic [8*NB-1:0] result,
  input  logic [LW-1:0]   len,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            last_fire
);

  // Handshake: a byte moves when tx_valid && tx_ready on a rising edge;
  // tx_data and tx_valid only change on load or on such a transfer.
  logic [8*(NB+1)-1:0] shreg;
  logic [LW-1:0]       remain;
  logic                fire;

  assign tx_data   = shreg[7:0];
  assign fire      = tx_valid && tx_ready;
  assign last_fire = fire && (remain == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      remain   <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= {result, status};
      remain   <= len - LW'(1);
      tx_valid <= 1'b1;
    end else if (fire) begin
      shreg <= shreg >> 8;
      if (remain == '0) begin
        tx_valid <= 1'b0;
      end else begin
        remain <= remain - LW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Command sequencer between the host byte link and the calculator core:
// assembles op/operand frames, runs the core, and streams back a response.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] calc_opa,
  output logic [DATA_WIDTH-1:0] calc_opb,
  output logic [2:0]            calc_op,
  output logic                  calc_start,
  input  logic                  calc_ready,
  input  logic                  calc_done,
  input  logic [DATA_WIDTH-1:0] calc_result,
  output logic                  busy,
  output seq_state_e            fsm_state
);

  // DATA_WIDTH must be a non-zero multiple of 8; TIMEOUT_CYCLES must be >= 2.
  localparam int NB  = DATA_WIDTH / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW  = $clog2(NB + 2);

  seq_state_e     state;
  logic [7:0]     op_code;
  logic [BCW-1:0] byte_cnt;
  logic [TW-1:0]  wait_cnt;
  logic           rx_fire;
  logic           last_byte;
  logic           frame_ok;
  logic           timeout_hit;
  logic           ser_load;
  logic [7:0]     ser_status;
  logic [LW-1:0]  ser_len;
  logic           ser_last;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                     input logic [7:0] b);
    return DATA_WIDTH'({b, cur} >> 8);
  endfunction

  assign fsm_state   = state;
  assign rx_fire     = rx_valid && rx_ready;
  assign last_byte   = (byte_cnt == BCW'(NB - 1));
  assign frame_ok    = op_code_valid(op_code);
  assign calc_start  = (state == ST_ISSUE) && calc_ready;
  // wait_cnt reads k in the k-th cycle after start; the transition taken here
  // puts the timeout status on the link exactly TIMEOUT_CYCLES after start.
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    ser_load   = 1'b0;
    ser_status = STAT_OK;
    if (state == ST_RX_B && rx_fire && last_byte && !frame_ok) begin
      ser_load   = 1'b1;
      ser_status = STAT_BAD_OP;
    end else if (state == ST_WAIT) begin
      if (calc_done) begin
        ser_load   = 1'b1;
        ser_status = STAT_OK;
      end else if (timeout_hit) begin
        ser_load   = 1'b1;
        ser_status = STAT_TIMEOUT;
      end
    end
    ser_len = (ser_status == STAT_OK) ? LW'(NB + 1) : LW'(1);
  end

  calc_tx_serializer #(.NB(NB), .LW(LW)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .status   (ser_status),
    .result   (calc_result),
    .len      (ser_len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .last_fire(ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RX_OP;
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      op_code  <= '0;
      byte_cnt <= '0;
      wait_cnt <= '0;
      calc_opa <= '0;
      calc_opb <= '0;
      calc_op  <= '0;
    end else begin
      case (state)
        ST_RX_OP: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            op_code  <= rx_data;
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_RX_A;
          end
        end
        ST_RX_A: begin
          if (rx_fire) begin
            calc_opa <= shift_in(calc_opa, rx_data);
            if (last_byte) begin
              byte_cnt <= '0;
              state    <= ST_RX_B;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        ST_RX_B: begin
          if (rx_fire) begin
            calc_opb <= shift_in(calc_opb, rx_data);
            if (last_byte) begin
              byte_cnt <= '0;
              rx_ready <= 1'b0;
              if (frame_ok) begin
                calc_op <= op_code[2:0];
                state   <= ST_ISSUE;
              end else begin
                state <= ST_TX_STATUS;
              end
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (calc_ready) begin
            wait_cnt <= TW'(1);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The result itself is captured by the serializer on ser_load.
          if (calc_done || timeout_hit) begin
            state <= ST_TX_STATUS;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_TX_STATUS: begin
          if (ser_last) begin
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_RX_OP;
          end else if (tx_valid && tx_ready) begin
            state <= ST_TX_RES;
          end
        end
        ST_TX_RES: begin
          if (ser_last) begin
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_RX_OP;
          end
        end
        default: begin
          state <= ST_RX_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with DATA_WIDTH=16, TIMEOUT_CYCLES=16;
// the bench plays host link and calculator core.
module tb_calc_cmd_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] calc_opa;
  logic [15:0] calc_opb;
  logic [2:0]  calc_op;
  logic        calc_start;
  logic        calc_ready;
  logic        calc_done;
  logic [15:0] calc_result;
  logic        busy;
  seq_state_e  fsm_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int start_cnt = 0;
  logic [7:0] exp_q[$];

  calc_cmd_sequencer #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .calc_opa(calc_opa), .calc_opb(calc_opb), .calc_op(calc_op),
    .calc_start(calc_start), .calc_ready(calc_ready), .calc_done(calc_done),
    .calc_result(calc_result), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / start monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (calc_start) start_cnt <= start_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!rx_ready) check_eq("rx_accept", rx_ready, 1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    send_byte(op);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  task automatic core_done(input logic [15:0] res);
    calc_result = res;
    calc_done   = 1'b1;
    step();
    calc_done   = 1'b0;
  endtask

  // scoreboard: drain exp_q against the tx stream, optionally stalling tx_ready
  task automatic recv_resp(input bit rnd);
    int guard;
    logic [7:0] held;
    bit stalled;
    guard = 0;
    held = 8'h00;
    stalled = 1'b0;
    while (exp_q.size() != 0 && guard < 200) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check_eq("tx_hold_valid", tx_valid, 1);
        check_eq("tx_hold_data", tx_data, held);
      end
      if (tx_valid && tx_ready) begin
        check_eq("tx_byte", tx_data, exp_q.pop_front());
        stalled = 1'b0;
      end else if (tx_valid) begin
        stalled = 1'b1;
        held = tx_data;
      end
      step();
      guard++;
    end
    tx_ready = 1'b0;
    if (exp_q.size() != 0) begin
      check_eq("tx_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    check_eq("tx_idle", tx_valid, 0);
    check_eq("rx_ready_back", rx_ready, 1);
    check_eq("busy_clear", busy, 0);
  endtask

  task automatic do_txn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input int lat, input bit rnd);
    int s0;
    s0 = start_cnt;
    send_frame(op, a, b);
    check_eq("start_now", calc_start, 1);
    check_eq("opa", calc_opa, a);
    check_eq("opb", calc_opb, b);
    check_eq("op", calc_op, op[2:0]);
    step();
    repeat (lat) step();
    core_done(res);
    check_eq("tx_valid_after_done", tx_valid, 1);
    check_eq("start_count", start_cnt - s0, 1);
    exp_q.push_back(STAT_OK);
    exp_q.push_back(res[7:0]);
    exp_q.push_back(res[15:8]);
    recv_resp(rnd);
  endtask

  logic [7:0] bad_ops[4];

  initial begin
    int s0;
    int cyc;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    calc_ready = 1'b1;
    calc_done = 1'b0;
    calc_result = 16'h0000;
    bad_ops[0] = 8'h00;
    bad_ops[1] = 8'h09;
    bad_ops[2] = 8'h07;
    bad_ops[3] = 8'h85;

    // reset state
    repeat (3) step();
    check_eq("rst_rx_ready", rx_ready, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_start", calc_start, 0);
    check_eq("rst_opa", calc_opa, 0);
    check_eq("rst_opb", calc_opb, 0);
    check_eq("rst_op", calc_op, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    check_eq("rx_ready_rise", rx_ready, 1);

    // add
    do_txn(8'h01, 16'h1234, 16'h0101, 16'h1335, 3, 1'b0);

    // invalid op codes: frame consumed, status 01 only, no start
    foreach (bad_ops[i]) begin
      s0 = start_cnt;
      send_frame(bad_ops[i], 16'hBBAA, 16'hDDCC);
      check_eq("bad_no_start", calc_start, 0);
      check_eq("bad_tx_valid", tx_valid, 1);
      exp_q.push_back(STAT_BAD_OP);
      recv_resp(1'b0);
      check_eq("bad_start_count", start_cnt - s0, 0);
    end

    // timeout: status 02 appears 16 cycles after start; late done ignored
    send_frame(8'h03, 16'h0002, 16'h0003);
    check_eq("to_start", calc_start, 1);
    step();
    cyc = 1;
    while (!tx_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check_eq("to_latency", cyc, 16);
    core_done(16'hBEEF);
    exp_q.push_back(STAT_TIMEOUT);
    recv_resp(1'b0);
    core_done(16'hBEEF);
    check_eq("late_done_idle", tx_valid, 0);
    do_txn(8'h01, 16'h0005, 16'h0007, 16'h000C, 2, 1'b0);

    // calc_ready low for 5 cycles holds off a single start pulse
    s0 = start_cnt;
    calc_ready = 1'b0;
    send_frame(8'h04, 16'h0064, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      check_eq("start_held", calc_start, 0);
      step();
    end
    check_eq("issue_busy", busy, 1);
    calc_ready = 1'b1;
    #1;
    check_eq("start_released", calc_start, 1);
    step();
    check_eq("start_single", calc_start, 0);
    core_done(16'h0014);
    check_eq("div_start_count", start_cnt - s0, 1);
    exp_q.push_back(STAT_OK);
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h00);
    recv_resp(1'b0);

    // gcd with random tx backpressure
    do_txn(8'h06, 16'h0030, 16'h0012, 16'h0006, 4, 1'b1);

    // reset while waiting on the core
    send_frame(8'h02, 16'h0100, 16'h0001);
    check_eq("rw_start", calc_start, 1);
    step();
    step();
    check_eq("rw_in_wait", fsm_state, ST_WAIT);
    rst = 1'b1;
    step();
    check_eq("rw_tx_valid", tx_valid, 0);
    check_eq("rw_busy", busy, 0);
    rst = 1'b0;
    step();
    do_txn(8'h02, 16'h0010, 16'h0003, 16'h000D, 1, 1'b0);

    // reset in the middle of the result bytes
    send_frame(8'h01, 16'h1000, 16'h0111);
    check_eq("rt_start", calc_start, 1);
    step();
    core_done(16'h1111);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check_eq("rt_in_tx_res", fsm_state, ST_TX_RES);
    check_eq("rt_tx_data", tx_data, 8'h11);
    rst = 1'b1;
    step();
    check_eq("rt_tx_valid", tx_valid, 0);
    check_eq("rt_busy", busy, 0);
    rst = 1'b0;
    step();
    do_txn(8'h02, 16'h0010, 16'h0003, 16'h000D, 0, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
